// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from an upstream FIFO read port and serialises each
// one as an 8N1 UART frame (start bit, 8 data bits LSB first, stop bit).
// Every bit is held for CLKS_PER_BIT clock cycles.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit, giving 8E1 frames.

module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_rdata,
    output logic       fifo_rinc,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } state_t;
`endif

    state_t            state;
    state_t            state_next;
    logic              armed;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BAUD_W-1:0] baud_next;
    logic [2:0]        bit_idx;
    logic [2:0]        bit_next;
    logic [7:0]        shift_reg;
    logic [7:0]        shift_next;
    logic              tx_next;
    logic              bit_end;
`ifdef UART_TX_PARITY_EN
    logic              parity_reg;
    logic              parity_next;
`endif

    // The last cycle of every serial bit is where the FSM advances.
    assign bit_end = (baud_cnt == BAUD_LAST);
    assign busy    = (state != IDLE);

    // State register. 'armed' keeps fifo_rinc low until the first clock edge
    // after reset releases, so a pop can never coincide with reset removal.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            armed <= 1'b0;
        end else begin
            state <= state_next;
            armed <= 1'b1;
        end
    end

    // Datapath registers: baud/bit counters, shift register and the serial line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            tx         <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            baud_cnt   <= baud_next;
            bit_idx    <= bit_next;
            shift_reg  <= shift_next;
            tx         <= tx_next;
`ifdef UART_TX_PARITY_EN
            parity_reg <= parity_next;
`endif
        end
    end

    // Next-state, counter and output decode; tx_next is derived from the state
    // being entered so the registered tx lines up with the state it belongs to.
    always_comb begin
        state_next  = state;
        baud_next   = baud_cnt;
        bit_next    = bit_idx;
        shift_next  = shift_reg;
        fifo_rinc   = 1'b0;
        tx_done     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next = parity_reg;
`endif

        case (state)
            IDLE: begin
                fifo_rinc = armed && !fifo_empty;
                if (fifo_rinc) begin
                    state_next = FETCH;
                end
            end

            FETCH: begin
                shift_next  = fifo_rdata;
                baud_next   = '0;
                bit_next    = '0;
`ifdef UART_TX_PARITY_EN
                parity_next = ^fifo_rdata;
`endif
                state_next  = START;
            end

            START: begin
                if (bit_end) begin
                    baud_next  = '0;
                    state_next = DATA;
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end

            DATA: begin
                if (bit_end) begin
                    baud_next  = '0;
                    shift_next = {1'b0, shift_reg[7:1]};
                    bit_next   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    baud_next  = '0;
                    state_next = STOP;
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
`endif

            STOP: begin
                if (bit_end) begin
                    tx_done    = 1'b1;
                    baud_next  = '0;
                    state_next = IDLE;
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
                baud_next  = '0;
                bit_next   = '0;
            end
        endcase

        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_next = parity_reg;
`endif
            default: tx_next = 1'b1;
        endcase
    end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; legal range 2..65535.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 fifo_empty  input  1  empty flag from the upstream FIFO read port, synchronous to clk.
REQ-005 fifo_rdata  input  8  FIFO read data; it is registered and valid in the cycle after fifo_rinc is asserted.
REQ-006 fifo_rinc  output  1  FIFO pop request, one cycle per byte.
REQ-007 tx  output  1  serial line; idles high.
REQ-008 busy  output  1  high whenever the FSM is not in IDLE.
REQ-009 tx_done  output  1  one-cycle pulse on the last cycle of a stop bit.

Function
REQ-010 The FSM SHALL have the states IDLE, FETCH, START, DATA, PARITY (only when the macro is enabled) and STOP.
REQ-011 IDLE: fifo_rinc = !fifo_empty, decoded combinationally; when fifo_empty=0, the next state is FETCH; otherwise the FSM remains in IDLE.
REQ-012 fifo_rinc SHALL never be asserted outside IDLE, and SHALL never be asserted while fifo_empty=1.
REQ-013 FETCH (1 cycle): fifo_rdata is latched into an 8-bit shift register; the bit counter and baud counter are cleared; the next state is START.
REQ-014 START: tx=0 for CLKS_PER_BIT cycles, then the next state is DATA.
REQ-015 DATA: 8 bits are sent LSB first, each held for CLKS_PER_BIT cycles; after bit 7, the next state is PARITY if enabled, else STOP.
REQ-016 STOP: tx=1 for CLKS_PER_BIT cycles; tx_done=1 on the final cycle; the next state is IDLE.
REQ-017 The baud counter SHALL be $clog2(CLKS_PER_BIT) bits wide, count 0..CLKS_PER_BIT-1, and wrap to 0 at each bit boundary; the bit index is 3 bits.
REQ-018 tx SHALL be registered, with no combinational path from any input to tx.
REQ-019 Frame length SHALL be 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT cycles with parity.
REQ-020 Back-to-back frames: when fifo_empty=0 at the end of STOP, the gap is exactly 2 cycles of tx=1 (IDLE + FETCH) before the next start bit.
REQ-021 fifo_empty changing outside IDLE SHALL have no effect on the frame in progress.
REQ-022 fifo_rdata SHALL be sampled only in FETCH; changes at any other time are ignored.

Reset
REQ-023 On rst_n=0, the block SHALL asynchronously set state=IDLE, tx=1, busy=0, tx_done=0, all counters to 0 and the shift register to 0.
REQ-024 fifo_rinc SHALL be 0 during reset.
REQ-025 A reset mid-frame SHALL abort the frame immediately (tx=1); the byte is discarded, not re-fetched.
REQ-026 The first fifo_rinc SHALL occur no earlier than the first posedge clk after rst_n deasserts.

Configuration
REQ-027 The macro UART_TX_PARITY_EN, when defined, SHALL insert the PARITY state after DATA, driving tx = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles.
REQ-028 When UART_TX_PARITY_EN is undefined, the PARITY state, its logic and its encoding SHALL be absent, and DATA SHALL proceed directly to STOP.

Verification (CLKS_PER_BIT=4)
REQ-029 Reset with fifo_empty=1 for 50 cycles -> tx=1, busy=0 and fifo_rinc=0 throughout.
REQ-030 One byte 0xA5, parity off -> exactly one fifo_rinc pulse; tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; tx_done pulses once, 40 cycles after the start bit begins.
REQ-031 Bytes 0x01 then 0xFF queued, parity on -> 0x01 sends parity bit 1, 0xFF sends parity bit 0; 44 cycles per frame; 2 idle-high cycles between frames.
REQ-032 rst_n pulsed low during DATA bit 3 of 0x3C -> tx=1 within the same cycle; busy=0; no further fifo_rinc until fifo_empty=0 is sampled in IDLE.
REQ-033 fifo_empty toggled every cycle during a frame of 0x55 -> no fifo_rinc until STOP completes; the frame is bit-exact.
REQ-034 16 random bytes preloaded into the FIFO -> 16 fifo_rinc pulses and 16 frames, decoded by a bench UART receiver as the same bytes in order.
